// File: rtl/cic_comp_pkg.sv
// cic_comp_pkg: widths, coefficients and state type shared by cic_comp_fir and cic_comp_mac.
// Optional macro CIC_COMP_SAT_EN (used by the RTL) selects output saturation.
package cic_comp_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int COEF_WIDTH = 16;
    localparam int NUM_TAPS   = 8;
    localparam int ACC_WIDTH  = 40;
    localparam int FRAC_BITS  = 15;
    localparam int IDX_WIDTH  = $clog2(NUM_TAPS);
    typedef enum logic [1:0] {IDLE, MAC, OUT} comp_state_t;
    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic signed [COEF_WIDTH-1:0] coef_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod_t;
    typedef logic [IDX_WIDTH-1:0] idx_t;
    // Q15 taps summing to 32768 for unity DC gain
    localparam coef_t COEFS [NUM_TAPS] = '{
        coef_t'(-1024), coef_t'(0), coef_t'(5120), coef_t'(12288),
        coef_t'(12288), coef_t'(5120), coef_t'(0), coef_t'(-1024)
    };
endpackage

// File: rtl/cic_comp_mac.sv
// cic_comp_mac: signed multiply-accumulate with sync clear and a round-half-up output stage.
// With CIC_COMP_SAT_EN the output clamps and reports sat; otherwise it wraps.
module cic_comp_mac import cic_comp_pkg::*; (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    clr,
    input  logic    en,
    input  sample_t sample,
    input  coef_t   coef,
    output sample_t result
`ifdef CIC_COMP_SAT_EN
    ,
    output logic    sat
`endif
);
    localparam acc_t HALF = acc_t'(1) <<< (FRAC_BITS - 1);
    acc_t  acc;
    acc_t  sum;
    prod_t prod;
    assign prod = prod_t'(sample) * prod_t'(coef);
    // result is formed from the running sum so the last product lands in the same cycle
    assign sum = acc + acc_t'(prod);
`ifdef CIC_COMP_SAT_EN
    localparam acc_t SMAX = (acc_t'(1) <<< (DATA_WIDTH - 1)) - acc_t'(1);
    localparam acc_t SMIN = -SMAX - acc_t'(1);
    acc_t rnd;
    assign rnd = (sum + HALF) >>> FRAC_BITS;
    assign sat = (rnd > SMAX) || (rnd < SMIN);
    assign result = rnd > SMAX ? sample_t'(SMAX) : rnd < SMIN ? sample_t'(SMIN) : sample_t'(rnd);
`else
    assign result = sample_t'((sum + HALF) >>> FRAC_BITS);
`endif
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) acc <= '0;
        else if (clr) acc <= '0;
        else if (en) acc <= sum;
endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: CIC droop compensation FIR, serial MAC one tap per clock, valid/ready on both sides.
// Define CIC_COMP_SAT_EN for saturating output and the sat_flag port.
module cic_comp_fir import cic_comp_pkg::*; (
    input  logic    clk,
    input  logic    reset_n,
    input  sample_t in_data,
    input  logic    in_valid,
    output logic    in_ready,
    output sample_t out_data,
    output logic    out_valid,
    input  logic    out_ready
`ifdef CIC_COMP_SAT_EN
    ,
    output logic    sat_flag
`endif
);
    comp_state_t state, next;
    sample_t     x [NUM_TAPS];
    idx_t        idx;
    sample_t     result;
    logic        accept, last;
`ifdef CIC_COMP_SAT_EN
    logic        sat;
`endif
    assign in_ready = reset_n && state == IDLE;
    assign accept   = in_valid && in_ready;
    assign last     = state == MAC && idx == idx_t'(NUM_TAPS - 1);
    cic_comp_mac u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .en      (state == MAC),
        .sample  (x[idx]),
        .coef    (COEFS[idx]),
        .result  (result)
`ifdef CIC_COMP_SAT_EN
        ,
        .sat     (sat)
`endif
    );
    always_comb next = accept ? MAC : last ? OUT : (state == OUT && out_ready) ? IDLE : state;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= next;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef CIC_COMP_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                x[0] <= in_data;
                for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
            end
            idx <= accept ? '0 : state == MAC ? idx + 1'b1 : idx;
            if (last) begin
                out_data  <= result;
                out_valid <= 1'b1;
`ifdef CIC_COMP_SAT_EN
                sat_flag  <= sat;
`endif
            end else if (state == OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: directed and randomized checks of cic_comp_fir against a convolution model.
// Honors CIC_COMP_SAT_EN to expect clamped outputs and sat_flag.
module tb_cic_comp_fir;
    import cic_comp_pkg::*;
    logic    clk = 1'b0, reset_n = 1'b0;
    sample_t in_data = '0;
    logic    in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    sample_t out_data;
`ifdef CIC_COMP_SAT_EN
    logic    sat_flag;
`endif
    typedef struct {int data; bit sat;} exp_t;
    localparam int C [8]   = '{-1024, 0, 5120, 12288, 12288, 5120, 0, -1024};
    localparam int IMP [8] = '{-512, 0, 2560, 6144, 6144, 2560, 0, -512};
    int   vectors = 0, miscompares = 0, cyc = 0;
    int   hist [8];
    exp_t expq[$];
    exp_t e_cur;
    int   got[$];
    bit   got_sat[$];
    int   acc_edges[$];
    int   n_acc = 0, n_xfer = 0, last_acc = 0, n0_acc, n0_xfer;
    logic prev_ov = 1'b0, prev_xfer = 1'b0;
    sample_t prev_data = '0;

    cic_comp_fir dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CIC_COMP_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model();
        longint s = 0;
        longint r;
        sample_t w;
        exp_t e;
        for (int k = 0; k < 8; k++) s += longint'(hist[k]) * C[k];
        r = (s + 16384) >>> 15;
`ifdef CIC_COMP_SAT_EN
        e.sat  = r > 32767 || r < -32768;
        e.data = r > 32767 ? 32767 : r < -32768 ? -32768 : int'(r);
`else
        w      = r[15:0];
        e.sat  = 1'b0;
        e.data = w;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            foreach (hist[k]) hist[k] = 0;
            expq.delete();
            check("reset_out_valid", out_valid, 0);
            check("reset_in_ready", in_ready, 0);
            prev_ov = 1'b0;
            prev_xfer = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = in_data;
                expq.push_back(model());
                acc_edges.push_back(cyc + 1);
                last_acc = cyc + 1;
                n_acc++;
            end
            if (out_valid && !prev_ov) check("latency", cyc - last_acc, NUM_TAPS);
            if (out_valid && prev_ov && !prev_xfer) check("hold_data", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got %0d with no pending input", out_data);
                end else begin
                    e_cur = expq.pop_front();
                    check("out_data", out_data, e_cur.data);
`ifdef CIC_COMP_SAT_EN
                    check("sat_flag", sat_flag, e_cur.sat);
                    got_sat.push_back(sat_flag);
`endif
                end
                got.push_back(out_data);
                n_xfer++;
            end
            prev_ov = out_valid;
            prev_xfer = out_valid && out_ready;
            prev_data = out_data;
        end
    end

    task automatic send(input int v);
        int n = 0;
        in_data = sample_t'(v);
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send: in_ready stuck low for value %0d", v);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d outputs pending, expected 0", expq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_data", out_data, 0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
        send(16384);
        repeat (7) send(0);
        drain();
        check("impulse_count", got.size(), 8);
        for (int i = 0; i < 8; i++) check("impulse", got[i], IMP[i]);
        got.delete();
        acc_edges.delete();
        repeat (12) send(1000);
        drain();
        for (int i = 7; i < 12; i++) check("dc", got[i], 1000);
        for (int i = 1; i < 12; i++) check("dc_spacing", acc_edges[i] - acc_edges[i-1], NUM_TAPS + 2);
        out_ready = 1'b0;
        send(500);
        n0_acc = n_acc;
        n0_xfer = n_xfer;
        in_data = 777;
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
        end
        check("bp_no_accept", n_acc, n0_acc);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_one_xfer", n_xfer, n0_xfer + 1);
        check("bp_accept_next", n_acc, n0_acc + 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        got.delete();
        got_sat.delete();
        repeat (8) send(-32768);
        repeat (6) send(32767);
        drain();
`ifdef CIC_COMP_SAT_EN
        check("overflow", got[13], 32767);
        check("overflow_sat", got_sat[13], 1);
`else
        check("overflow", got[13], -30721);
`endif
        n0_xfer = n_xfer;
        send(16384);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_no_output", n_xfer, n0_xfer);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        got.delete();
        send(16384);
        repeat (7) send(0);
        drain();
        check("impulse2_count", got.size(), 8);
        for (int i = 0; i < 8; i++) check("impulse_after_reset", got[i], IMP[i]);
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data = sample_t'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
